bcd_count_chain: RTL
====================

Name: bcd_count_chain

Overview:
- Three-decade BCD up/down counter with a built-in prescaler. It produces the digit values CNT1 (ones), CNT2 (tens) and CNT3 (hundreds).
- Sits directly upstream of the digit selector, which picks one of the three values for the seven-segment decoder.
- Counts only on prescaler ticks, so a fast board clock yields a human-visible count rate.
- Supports wrap-around with an overflow/underflow pulse.

Parameters:
- PRESCALE, 50000000: number of enabled CLK cycles per count step; must be >= 1. The value 1 means a step on every enabled cycle.
- PRE_W, max(1, clog2(PRESCALE)): width of the prescaler register; derived, not overridden.

Ports:
- CLK  input  1  system clock; all state is updated on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- EN  input  1  count enable; gates the prescaler.
- UP  input  1  direction: 1 = increment, 0 = decrement. Sampled only on the step cycle.
- CLR  input  1  synchronous clear of the digits and prescaler.
- CNT1  output  4  ones digit, BCD 0-9, registered.
- CNT2  output  4  tens digit, BCD 0-9, registered.
- CNT3  output  4  hundreds digit, BCD 0-9, registered.
- TICK  output  1  one-cycle pulse, high in the cycle the new count first appears on CNT1-3.
- OVF  output  1  one-cycle pulse on wrap: 999->000 going up, or 000->999 going down. Coincident with TICK.

Behaviour:
- Reset (RST low): asynchronously sets prescaler, CNT1, CNT2, CNT3, TICK and OVF to 0. This applies immediately, including mid-count. Counting restarts from 000 with a fresh prescale period after RST deasserts.
- Prescaler:
  - While EN=1, pre increments each cycle.
  - When pre == PRESCALE-1 and EN=1, that cycle is a step cycle: pre reloads to 0.
  - While EN=0, pre holds its value, and the digits, TICK and OVF hold/clear as below.
- Step latency: the edge ending a step cycle updates the digits. On the same edge TICK<=1 and OVF<=wrap, so both pulses align with the new digit values. On all other cycles TICK<=0 and OVF<=0.
- Up step: CNT1+1. A digit at 9 goes to 0 and carries to the next decade. Carry ripples combinationally within the single step. At 999, all digits go to 0 and OVF=1.
- Down step: CNT1-1. A digit at 0 goes to 9 and borrows from the next decade. At 000, all digits go to 9 and OVF=1.
- Direction: UP is taken only from the step cycle. Changing UP mid-period has no other effect.
- CLR=1:
  - On the next edge: pre<=0, digits<=000, TICK<=0, OVF<=0.
  - Takes priority over a coincident step and does not depend on EN.
- Invalid BCD codes (10-15) are unreachable and need no handling.
- No combinational path from any input to any output.

Decomposition:
- Shared package holds:
  - DIGIT_MAX = 4'd9
  - DIGIT_MIN = 4'd0
  - DIGIT_W = 4
- Sub-module bcd_digit: one decade, purely combinational, instantiated three times and chained carry/borrow from ones to hundreds.
  - Inputs: d[3:0], step, up.
  - Outputs: next digit, carry_out (asserted when step and (up ? d==9 : d==0)).
  - The chain's final carry_out is the wrap condition that feeds OVF.

Test Plan (bench uses PRESCALE=4):
- Reset mid-count: count to 057, drop RST asynchronously between edges -> CNT1-3=0, TICK=0, OVF=0 immediately. Release -> first TICK after exactly 4 enabled cycles, count 001.
- Up carry: EN=1, UP=1 from 000 for 40 cycles -> TICK every 4th cycle. After step 9 the count is 009, after step 10 it is 010. After 100 steps the count is 100.
- Up wrap: preset by counting to 999, one more step -> 000 with TICK=1 and OVF=1 for exactly one cycle, then both 0.
- Down borrow/wrap: from 100, UP=0, one step -> 099. From 000, one step -> 999 with OVF=1 for one cycle. Toggling UP mid-period (UP=1 at pre=1, UP=0 at step cycle) -> decrement.
- Enable pause: EN=1 for 2 cycles, EN=0 for 5 cycles, EN=1 -> step occurs after 2 more enabled cycles. No TICK while EN=0.
- Clear priority: assert CLR on a step cycle at count 456 -> next cycle 000 with TICK=0, OVF=0. The next step follows 4 enabled cycles later with value 001.

Source files
------------

// File: rtl/bcd_count_chain_pkg.sv
// rtl/bcd_count_chain_pkg.sv - shared digit constants for the BCD counter chain
package bcd_count_chain_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] DIGIT_MIN = 4'd0;
endpackage

// File: rtl/bcd_count_chain_bcd_digit.sv
// rtl/bcd_count_chain_bcd_digit.sv - one combinational BCD decade with carry/borrow out
module bcd_digit
  import bcd_count_chain_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_i,
  input  logic               step_i,
  input  logic               up_i,
  output logic [DIGIT_W-1:0] next_o,
  output logic               carry_o
);
  always_comb begin
    next_o  = d_i;
    carry_o = 1'b0;
    if (step_i) begin
      if (up_i) begin
        if (d_i == DIGIT_MAX) begin
          next_o  = DIGIT_MIN;
          carry_o = 1'b1;
        end else begin
          next_o = d_i + 4'd1;
        end
      end else begin
        if (d_i == DIGIT_MIN) begin
          next_o  = DIGIT_MAX;
          carry_o = 1'b1;
        end else begin
          next_o = d_i - 4'd1;
        end
      end
    end
  end
endmodule

// File: rtl/bcd_count_chain.sv
// rtl/bcd_count_chain.sv - three-decade BCD up/down counter with prescaler and wrap pulse
module bcd_count_chain
  import bcd_count_chain_pkg::*;
#(
  parameter int PRESCALE = 50000000,
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic               UP,
  input  logic               CLR,
  output logic [DIGIT_W-1:0] CNT1,
  output logic [DIGIT_W-1:0] CNT2,
  output logic [DIGIT_W-1:0] CNT3,
  output logic               TICK,
  output logic               OVF
);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [DIGIT_W-1:0] d1_q, d2_q, d3_q;
  logic [DIGIT_W-1:0] d1_d, d2_d, d3_d;
  logic               tick_q, ovf_q;
  logic               step;
  logic               c1, c2, c3;

  assign step = EN && (pre_q == PRE_LAST);

  always_comb begin
    pre_d = pre_q;
    if (EN) begin
      pre_d = step ? '0 : pre_q + 1'b1;
    end
  end

  // Carry ripples ones -> tens -> hundreds within a single step.
  bcd_digit u_ones (.d_i(d1_q), .step_i(step), .up_i(UP), .next_o(d1_d), .carry_o(c1));
  bcd_digit u_tens (.d_i(d2_q), .step_i(c1),   .up_i(UP), .next_o(d2_d), .carry_o(c2));
  bcd_digit u_hund (.d_i(d3_q), .step_i(c2),   .up_i(UP), .next_o(d3_d), .carry_o(c3));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pre_q  <= '0;
      d1_q   <= DIGIT_MIN;
      d2_q   <= DIGIT_MIN;
      d3_q   <= DIGIT_MIN;
      tick_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (CLR) begin
      pre_q  <= '0;
      d1_q   <= DIGIT_MIN;
      d2_q   <= DIGIT_MIN;
      d3_q   <= DIGIT_MIN;
      tick_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      d1_q   <= d1_d;
      d2_q   <= d2_d;
      d3_q   <= d3_d;
      tick_q <= step;
      ovf_q  <= c3;
    end
  end

  assign CNT1 = d1_q;
  assign CNT2 = d2_q;
  assign CNT3 = d3_q;
  assign TICK = tick_q;
  assign OVF  = ovf_q;
endmodule
